ascii_uart_tx: RTL and testbench
================================

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit time (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, character FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the design is in reset while reset=0.
REQ-005 ascii_in  input  8  character code from the tilt letter mapper.
REQ-006 valid_in  input  1  one-cycle strobe; ascii_in is valid in any cycle where valid_in=1.
REQ-007 tx  output  1  UART serial line, idle high, registered.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame is in progress.
REQ-009 fifo_full  output  1  high when the FIFO holds FIFO_DEPTH characters.
REQ-010 drop_pulse  output  1  one-cycle pulse for each character discarded because the FIFO was full.

Function
REQ-011 FIFO write: on an edge with valid_in=1 and fifo_full=0 (pre-edge value), ascii_in SHALL be stored at the write pointer.
REQ-012 Full write: valid_in=1 with fifo_full=0 false SHALL discard the character and assert drop_pulse for the following cycle, even when a pop occurs on the same edge.
REQ-013 Simultaneous write and pop SHALL leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH; characters SHALL leave in arrival order.
REQ-014 The transmit FSM SHALL have states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-015 IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud and bit counters, set tx=0, and go to START on the same edge.
REQ-016 START: hold tx=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
REQ-017 DATA: send 8 bits LSB first, CLKS_PER_BIT cycles each; after bit 7, go to PARITY if the macro is enabled, else to STOP with tx=1.
REQ-018 STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE; back-to-back frames are separated by exactly one idle clock.
REQ-019 Latency: valid_in sampled at edge E, with the FIFO empty and the FSM in IDLE, SHALL give tx=0 from edge E+1.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1, sized $clog2(CLKS_PER_BIT); no fractional baud.
REQ-021 ascii_in and valid_in SHALL have no effect on a frame already in the shift register.

Reset
REQ-022 While reset=0, outputs SHALL be: tx=1, busy=0, fifo_full=0, drop_pulse=0; FSM in IDLE; pointers, occupancy and counters cleared.
REQ-023 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard the partial frame and all FIFO contents.
REQ-024 The first valid_in accepted SHALL be the one sampled on the first rising edge after reset deasserts.

Configuration
REQ-025 With macro UART_PARITY_EN defined, PARITY SHALL follow DATA and send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bit times.
REQ-026 Without UART_PARITY_EN, the PARITY state and its logic SHALL be absent; frame = 10 bit times (8N1).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-027 Send 0x41 ('A') once: tx=0 from E+1, then bits 1,0,0,0,0,0,1,0 and a stop bit of 1, each 4 clocks; busy falls after the stop bit.
REQ-028 Define UART_PARITY_EN and send 0x41, then 0x43: parity bit=0 for 0x41 and 1 for 0x43; each frame is 44 clocks.
REQ-029 Send 10 strobes on consecutive cycles ('A'..'J') while idle: 'A'..'I' are transmitted in order; fifo_full rises after the 9th strobe; 'J' is dropped with a single drop_pulse.
REQ-030 Send 20 characters spaced 50 clocks apart: all 20 are received in order (pointer wrap); no drop_pulse.
REQ-031 Assert reset during DATA bit 3 of 0x55 with 3 characters queued: tx=1 immediately; after release tx stays high and busy=0 until new input.
REQ-032 Pulse valid_in on the same edge that IDLE pops the last queued entry: occupancy remains 1, and the new character is sent after one idle clock.

Source files
------------

// File: rtl/ascii_uart_tx.sv
// Character FIFO feeding a UART transmitter: 8N1 by default, 8E1 when
// UART_PARITY_EN is defined (adds an even-parity bit after the data bits).
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       valid_in,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       drop_pulse
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  state_t           state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       frame_data, frame_next;
  logic             tx_next;
  logic             baud_done;

  assign fifo_full = (count == FULL_CNT);
  assign push      = valid_in && !fifo_full;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (count != '0) || (state != IDLE);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // NOTE: the storage array is deliberately not reset; only pointers and
  // occupancy define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ascii_in;
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= valid_in && fifo_full;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      frame_data <= '0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      frame_data <= frame_next;
      tx         <= tx_next;
    end
  end

  always_comb begin
    // NOTE: every next value defaults to its current value so no path infers a latch.
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    frame_next = frame_data;
    tx_next    = tx;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (pop) begin
          frame_next = mem[rd_ptr];
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          tx_next    = frame_data[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_next    = ^frame_data;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_cnt + 3'd1;
            tx_next  = frame_data[bit_cnt + 3'd1];
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        // Leaving STOP lands in IDLE for one clock before the next pop.
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Self-checking bench for ascii_uart_tx: queue-based waveform model checked
// every cycle, a serial receiver, a frame table and directed corner sequences.
module tb_ascii_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] ascii_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       tx, busy, fifo_full, drop_pulse;

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ascii_in   (ascii_in),
    .valid_in   (valid_in),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a character queue plus a queue of future line samples.
  // Each pop expands one character into its full bit-time waveform followed
  // by a single idle sample; entries are {in_frame, tx}.
  logic [7:0]       m_fifo[$];
  logic [1:0]       m_wave[$];
  logic             exp_tx = 1'b1, exp_busy = 1'b0, exp_full = 1'b0, exp_drop = 1'b0;
  logic             m_full_pre, m_frame;
  logic [7:0]       m_head;
  logic [NBITS-1:0] m_bits;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_wave.delete();
      exp_tx = 1'b1; exp_busy = 1'b0; exp_full = 1'b0; exp_drop = 1'b0;
    end else begin
      m_full_pre = (m_fifo.size() == DEPTH);
      if (m_wave.size() == 0 && m_fifo.size() != 0) begin
        m_head    = m_fifo.pop_front();
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = m_head[i];
`ifdef UART_PARITY_EN
        m_bits[9] = ^m_head;
`endif
        m_bits[NBITS-1] = 1'b1;
        for (int b = 0; b < NBITS; b++)
          for (int k = 0; k < CPB; k++) m_wave.push_back({1'b1, m_bits[b]});
        m_wave.push_back(2'b01);
      end
      if (valid_in && !m_full_pre) m_fifo.push_back(ascii_in);
      exp_drop = valid_in && m_full_pre;
      if (m_wave.size() != 0) {m_frame, exp_tx} = m_wave.pop_front();
      else begin
        m_frame = 1'b0;
        exp_tx  = 1'b1;
      end
      exp_busy = m_frame || (m_fifo.size() != 0);
      exp_full = (m_fifo.size() == DEPTH);
    end
  end

  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("model_tx", 32'(tx), 32'(exp_tx));
      check("model_busy", 32'(busy), 32'(exp_busy));
      check("model_full", 32'(fifo_full), 32'(exp_full));
      check("model_drop", 32'(drop_pulse), 32'(exp_drop));
    end
  end

  // Serial receiver sampling mid-bit; a frame with a bad stop bit is not queued.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  int         rx_cnt  = -1;
  int         drop_seen = 0;

  always @(negedge clk or negedge reset) begin
    if (!reset) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (tx == 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
        rx_byte[rx_cnt / CPB - 1] = tx;
      if (rx_cnt == (NBITS - 1) * CPB + CPB / 2) begin
        if (tx) rx_q.push_back(rx_byte);
        rx_cnt = -1;
      end
    end
  end

  always @(negedge clk) if (reset && drop_pulse) drop_seen++;

  task automatic send(input logic [7:0] ch);
    @(negedge clk); valid_in = 1'b1; ascii_in = ch;
    @(negedge clk); valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input int base, input logic [7:0] exp_chars[$]);
    check({name, "_count"}, 32'(rx_q.size() - base), 32'(exp_chars.size()));
    for (int i = 0; i < exp_chars.size() && base + i < rx_q.size(); i++)
      check($sformatf("%s_%0d", name, i), 32'(rx_q[base+i]), 32'(exp_chars[i]));
  endtask

  typedef struct {
    logic [7:0]       ch;
    logic [0:NBITS-1] bits;
  } frame_vec_t;

  frame_vec_t   vecs[5];
  logic [7:0]   exp_chars[$];
  int           base_rx, base_drop, n_strobe;

  initial begin
`ifdef UART_PARITY_EN
    vecs[0] = '{8'h41, 11'b0_10000010_0_1};
    vecs[1] = '{8'h43, 11'b0_11000010_1_1};
    vecs[2] = '{8'h55, 11'b0_10101010_0_1};
    vecs[3] = '{8'h00, 11'b0_00000000_0_1};
    vecs[4] = '{8'h80, 11'b0_00000001_1_1};
`else
    vecs[0] = '{8'h41, 10'b0_10000010_1};
    vecs[1] = '{8'h43, 10'b0_11000010_1};
    vecs[2] = '{8'h55, 10'b0_10101010_1};
    vecs[3] = '{8'h00, 10'b0_00000000_1};
    vecs[4] = '{8'h80, 10'b0_00000001_1};
`endif

    // Reset values; a strobe during reset is ignored.
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_full", 32'(fifo_full), 32'd0);
    check("reset_drop", 32'(drop_pulse), 32'd0);
    valid_in = 1'b1; ascii_in = 8'h7e;
    @(negedge clk); valid_in = 1'b0;
    check("reset_ignores_valid", 32'(busy), 32'd0);
    #2 reset = 1'b1;
    mon_en = 1'b1;

    // Frame table: latency, every bit mid-sample, busy falling after the stop bit.
    for (int v = 0; v < 5; v++) begin
      wait_idle("idle_before_vec");
      send(vecs[v].ch);
      for (int j = 1; j <= NBITS * CPB + 1; j++) begin
        @(negedge clk);
        if (j == 1) check("latency_tx", 32'(tx), 32'd0);
        if ((j - 1) % CPB == CPB / 2)
          check($sformatf("vec%0d_bit%0d", v, (j - 1) / CPB), 32'(tx), 32'(vecs[v].bits[(j - 1) / CPB]));
        if (j == NBITS * CPB) check("busy_last_stop", 32'(busy), 32'd1);
        if (j == NBITS * CPB + 1) check("busy_fall", 32'(busy), 32'd0);
      end
    end

    // Ten back-to-back strobes: nine kept, the tenth dropped.
    wait_idle("idle_before_burst");
    base_rx = rx_q.size(); base_drop = drop_seen;
    exp_chars.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 8) check("full_after_8", 32'(fifo_full), 32'd0);
      if (i == 9) check("full_after_9", 32'(fifo_full), 32'd1);
      valid_in = 1'b1; ascii_in = 8'h41 + 8'(i);
      if (i < 9) exp_chars.push_back(8'h41 + 8'(i));
    end
    @(negedge clk); valid_in = 1'b0;
    check("drop_pulse_high", 32'(drop_pulse), 32'd1);
    @(negedge clk);
    check("drop_pulse_single", 32'(drop_pulse), 32'd0);
    wait_idle("idle_after_burst");
    check("burst_drop_count", 32'(drop_seen - base_drop), 32'd1);
    check_rx("burst_rx", base_rx, exp_chars);

    // Push on the same edge that pops the last entry; occupancy must stay 1,
    // so seven more strobes fill the FIFO exactly.
    wait_idle("idle_before_popwrite");
    base_rx = rx_q.size(); base_drop = drop_seen;
    exp_chars.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) check("popwrite_not_full", 32'(fifo_full), 32'd0);
      valid_in = 1'b1; ascii_in = 8'h61 + 8'(i);
      exp_chars.push_back(8'h61 + 8'(i));
    end
    @(negedge clk); valid_in = 1'b0;
    check("popwrite_full", 32'(fifo_full), 32'd1);
    repeat (NBITS * CPB - 7) @(negedge clk);
    check("idle_clock_tx", 32'(tx), 32'd1);
    check("idle_clock_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("second_start_tx", 32'(tx), 32'd0);
    wait_idle("idle_after_popwrite");
    check("popwrite_drops", 32'(drop_seen - base_drop), 32'd0);
    check_rx("popwrite_rx", base_rx, exp_chars);

    // Twenty characters spaced 50 clocks apart, wrapping the pointers.
    base_rx = rx_q.size(); base_drop = drop_seen;
    exp_chars.delete();
    for (int i = 0; i < 20; i++) begin
      send(8'h30 + 8'(i));
      exp_chars.push_back(8'h30 + 8'(i));
      repeat (48) @(negedge clk);
    end
    wait_idle("idle_after_spaced");
    check("spaced_drops", 32'(drop_seen - base_drop), 32'd0);
    check_rx("spaced_rx", base_rx, exp_chars);

    // Random traffic with bursts that overrun the FIFO.
    base_rx = rx_q.size(); base_drop = drop_seen; n_strobe = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 800 < 40) valid_in = ($urandom_range(0, 1) == 1);
      else              valid_in = ($urandom_range(0, 29) == 0);
      ascii_in = 8'($urandom_range(32, 126));
      if (valid_in) n_strobe++;
    end
    @(negedge clk); valid_in = 1'b0;
    wait_idle("idle_after_random");
    check("random_rx_count", 32'(rx_q.size() - base_rx), 32'(n_strobe - (drop_seen - base_drop)));

    // Reset during data bit 3 of 0x55 with three characters queued.
    base_rx = rx_q.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_in = 1'b1;
      ascii_in = (i == 0) ? 8'h55 : 8'h77 + 8'(i);
    end
    @(negedge clk); valid_in = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_reset_bit3", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_full", 32'(fifo_full), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_tx", 32'(tx), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_rx", 32'(rx_q.size() - base_rx), 32'd0);

    // First rising edge after reset release accepts a strobe.
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk); valid_in = 1'b1; ascii_in = 8'h5a;
    #2 reset = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    check("first_edge_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("first_edge_start", 32'(tx), 32'd0);
    wait_idle("idle_after_first_edge");
    exp_chars.delete();
    exp_chars.push_back(8'h5a);
    check_rx("first_edge_rx", rx_q.size() - 1, exp_chars);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
